cmd_frame_parser: RTL
=====================

// Module: cmd_frame_parser
// PURPOSE
//  Generalised successor command-frame parser on the CDC byte stream. Frame: 0x5A | CMD | LEN | PARA[LEN] | CHK.
//  Adds backpressure, inter-byte timeout, selectable check mode, and full parameter streaming out of an internal buffer.
//  Sits between the CDC RX path and the peripheral dispatcher (SPI/I2C/UART/PWM).
// PARAMETERS
//  MAX_PARA_LEN  64    buffer depth in bytes, 1..255; LEN > MAX_PARA_LEN is an error
//  CHK_MODE      1     0 = no check (CHK byte still consumed), 1 = 8-bit sum, 2 = CRC-8 (poly 0x07, init 0x00, MSB-first)
//  TIMEOUT_CYC   50000 max idle cycles between accepted bytes inside a frame; 0 disables the timeout
//  HEADER        8'h5A frame start byte
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  rx_data     in   8   CDC byte
//  rx_valid    in   1   byte valid
//  rx_ready    out  1   parser can accept a byte; transfer = rx_valid & rx_ready
//  cmd_valid   out  1   decoded command available; held until cmd_ready
//  cmd_ready   in   1   dispatcher takes the command
//  cmd_periph  out  3   CMD[7:5]
//  cmd_opcode  out  5   CMD[4:0]
//  para_len    out  8   LEN of the current command
//  para_data   out  8   parameter byte stream
//  para_valid  out  1   parameter byte valid
//  para_ready  in   1   consumer takes the byte
//  para_last   out  1   final parameter byte
//  frame_error out  1   one-cycle pulse on rejected frame
//  error_type  out  2   0 = reserved, 1 = checksum, 2 = length, 3 = timeout; held until the next error
//  err_cnt     out  16  saturating count of frame_error pulses
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, except rx_ready = 1. Reset mid-frame abandons the frame and clears the buffer index.
//  FSM:
//   IDLE: non-HEADER bytes are dropped silently; on HEADER -> CMD.
//   CMD -> LEN.
//   LEN: LEN > MAX_PARA_LEN -> error type 2, back to IDLE; later bytes are header-hunted.
//        LEN = 0 -> CHK; otherwise -> PARA.
//   PARA: byte i is written to buf[i]; after byte LEN-1 -> CHK.
//   CHK -> VERIFY.
//   VERIFY, 1 cycle: mismatch -> error type 1, then IDLE; pass -> CMD_OUT.
//   CMD_OUT: cmd_valid = 1 until cmd_ready; on handshake -> DRAIN (LEN > 0) or IDLE (LEN = 0).
//   DRAIN: buf[0..LEN-1] is sent under the para_valid/para_ready handshake; para_last = 1 on index LEN-1; after it -> IDLE.
//  rx_ready = 1 only in IDLE, CMD, LEN, PARA and CHK; it is 0 in VERIFY, CMD_OUT and DRAIN.
//  Check calculation:
//   Sum mode: 8-bit wrap sum of HEADER, CMD, LEN and PARA bytes; must equal CHK.
//   CRC mode: CRC over the same bytes; must equal CHK.
//   The accumulator restarts on every HEADER acceptance.
//  Timeout: the counter clears on each accepted byte and runs only in CMD..CHK.
//   When it reaches TIMEOUT_CYC: error type 3, go to IDLE.
//   A byte accepted on the same cycle as the terminal count wins; no error is raised.
//  frame_error asserts the cycle after the decisive byte/event; err_cnt increments on the same cycle and saturates at 0xFFFF.
//  cmd_periph/cmd_opcode/para_len update on entry to CMD_OUT and stay stable until the next CMD_OUT.
//  Latency: cmd_valid rises 2 cycles after the CHK byte is accepted.
// STRUCTURE
//  Package cmd_frame_pkg: HEADER default, PERIPH_* ids, ERR_* codes, CHK_MODE_* encodings, FSM state encoding.
//  Sub-module frame_chk_unit: clear/enable/byte in, 8-bit accumulator out, CHK_MODE parameter (sum or CRC-8).
//  Parameter buffer: inferred single-port RAM, MAX_PARA_LEN x 8; no reset on array contents.
// TESTING
//  1. Sum mode, bytes 5A 23 02 11 22 B2 -> cmd_periph = 1, cmd_opcode = 3, para_len = 2; para stream 11, 22 with para_last on 22; no error.
//  2. Same frame with CHK = B3 -> frame_error pulse, error_type = 1, err_cnt = 1; cmd_valid never asserts.
//  3. 5A 23 41 (MAX_PARA_LEN = 64) -> error_type = 2 the cycle after the LEN byte; a following valid frame still decodes.
//  4. TIMEOUT_CYC = 100: send 5A 23, then idle -> error_type = 3 exactly 100 cycles after 23; byte on cycle 100 -> no error.
//  5. 5A 41 00 9B, cmd_ready low for 10 cycles -> cmd_valid held and rx_ready = 0 for those 10 cycles; no para beats; garbage bytes FF 00 before 5A are dropped.
//  6. CHK_MODE = 2, random frames vs. CRC-8 model; para_ready toggled randomly -> stream order and para_last correct; rst mid-PARA -> IDLE, outputs at reset values.

Source files
------------

// File: rtl/cmd_frame_pkg.sv
// Shared constants, state encoding and CRC helper for the command-frame parser.
package cmd_frame_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'h5A;

    typedef enum logic [2:0] {
        PERIPH_SPI  = 3'd0,
        PERIPH_I2C  = 3'd1,
        PERIPH_UART = 3'd2,
        PERIPH_PWM  = 3'd3
    } periph_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_LENGTH   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam int unsigned CHK_MODE_NONE = 0;
    localparam int unsigned CHK_MODE_SUM  = 1;
    localparam int unsigned CHK_MODE_CRC8 = 2;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StLen,
        StPara,
        StChk,
        StVerify,
        StCmdOut,
        StDrain
    } state_e;

    // One byte of CRC-8, MSB first, no reflection, no final xor.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_chk_unit.sv
// Running frame check accumulator: 8-bit wrap sum or CRC-8, restartable per frame.
module frame_chk_unit
    import cmd_frame_pkg::*;
#(
    parameter int unsigned CHK_MODE = CHK_MODE_SUM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data,
    output logic [7:0] acc
);

    logic [7:0] acc_q, acc_d, base;

    // clear and enable together seed the accumulator with the current byte
    always_comb begin
        base  = clear ? 8'h00 : acc_q;
        acc_d = base;
        if (enable) begin
            if (CHK_MODE == CHK_MODE_SUM) begin
                acc_d = base + data;
            end else if (CHK_MODE == CHK_MODE_CRC8) begin
                acc_d = crc8_step(base, data);
            end else begin
                acc_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/cmd_frame_parser.sv
// Command-frame parser: 5A | CMD | LEN | PARA[LEN] | CHK with check, timeout,
// buffered parameter streaming and error reporting.
module cmd_frame_parser
    import cmd_frame_pkg::*;
#(
    parameter int unsigned MAX_PARA_LEN = 64,
    parameter int unsigned CHK_MODE     = CHK_MODE_SUM,
    parameter int unsigned TIMEOUT_CYC  = 50000,
    parameter logic [7:0]  HEADER       = HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_periph,
    output logic [4:0]  cmd_opcode,
    output logic [7:0]  para_len,
    output logic [7:0]  para_data,
    output logic        para_valid,
    input  logic        para_ready,
    output logic        para_last,
    output logic        frame_error,
    output logic [1:0]  error_type,
    output logic [15:0] err_cnt
);

    localparam int unsigned AddrW  = (MAX_PARA_LEN > 1) ? $clog2(MAX_PARA_LEN) : 1;
    localparam logic [7:0]  MaxLen = 8'(MAX_PARA_LEN);

    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  periph_q, periph_d;
    logic [4:0]  opcode_q, opcode_d;
    logic [7:0]  para_len_q, para_len_d;
    logic        frame_error_q;
    logic [1:0]  error_type_q, error_type_d;
    logic [15:0] err_cnt_q;

    logic [7:0]       mem [MAX_PARA_LEN];
    logic [AddrW-1:0] addr;
    logic             rx_fire, acc_clear, acc_en, mem_we, raise_err;
    logic [1:0]       err_code;
    logic [7:0]       acc;

    assign rx_ready = state_q inside {StIdle, StCmd, StLen, StPara, StChk};
    assign rx_fire  = rx_valid & rx_ready;
    // Write (PARA) and read (DRAIN) never overlap, so one index serves as the only address.
    assign addr     = idx_q[AddrW-1:0];

    frame_chk_unit #(
        .CHK_MODE(CHK_MODE)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .enable(acc_en),
        .data  (rx_data),
        .acc   (acc)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        chk_d      = chk_q;
        idx_d      = idx_q;
        timer_d    = 32'd0;
        periph_d   = periph_q;
        opcode_d   = opcode_q;
        para_len_d = para_len_q;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        mem_we     = 1'b0;
        raise_err  = 1'b0;
        err_code   = ERR_NONE;
        cmd_valid  = 1'b0;
        para_valid = 1'b0;
        para_last  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_fire && rx_data == HEADER) begin
                    acc_clear = 1'b1;
                    acc_en    = 1'b1;
                    state_d   = StCmd;
                end
            end
            StCmd: begin
                if (rx_fire) begin
                    cmd_d   = rx_data;
                    acc_en  = 1'b1;
                    state_d = StLen;
                end
            end
            StLen: begin
                if (rx_fire) begin
                    len_d  = rx_data;
                    idx_d  = 8'd0;
                    acc_en = 1'b1;
                    if (rx_data > MaxLen) begin
                        raise_err = 1'b1;
                        err_code  = ERR_LENGTH;
                        state_d   = StIdle;
                    end else if (rx_data == 8'd0) begin
                        state_d = StChk;
                    end else begin
                        state_d = StPara;
                    end
                end
            end
            StPara: begin
                if (rx_fire) begin
                    mem_we = 1'b1;
                    acc_en = 1'b1;
                    if (idx_q == len_q - 8'd1) begin
                        idx_d   = 8'd0;
                        state_d = StChk;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            StChk: begin
                if (rx_fire) begin
                    chk_d   = rx_data;
                    state_d = StVerify;
                end
            end
            StVerify: begin
                if (CHK_MODE == CHK_MODE_NONE || acc == chk_q) begin
                    periph_d   = cmd_q[7:5];
                    opcode_d   = cmd_q[4:0];
                    para_len_d = len_q;
                    state_d    = StCmdOut;
                end else begin
                    raise_err = 1'b1;
                    err_code  = ERR_CHECKSUM;
                    state_d   = StIdle;
                end
            end
            StCmdOut: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    idx_d   = 8'd0;
                    state_d = (len_q == 8'd0) ? StIdle : StDrain;
                end
            end
            StDrain: begin
                para_valid = 1'b1;
                para_last  = (idx_q == len_q - 8'd1);
                if (para_ready) begin
                    if (para_last) begin
                        idx_d   = 8'd0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // An accepted byte clears the timer, so it beats a coincident terminal count.
        if (state_q inside {StCmd, StLen, StPara, StChk} && !rx_fire) begin
            timer_d = timer_q + 32'd1;
            if (TIMEOUT_CYC != 0 && timer_d == TIMEOUT_CYC) begin
                raise_err = 1'b1;
                err_code  = ERR_TIMEOUT;
                idx_d     = 8'd0;
                state_d   = StIdle;
            end
        end

        error_type_d = raise_err ? err_code : error_type_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cmd_q         <= 8'd0;
            len_q         <= 8'd0;
            chk_q         <= 8'd0;
            idx_q         <= 8'd0;
            timer_q       <= 32'd0;
            periph_q      <= 3'd0;
            opcode_q      <= 5'd0;
            para_len_q    <= 8'd0;
            frame_error_q <= 1'b0;
            error_type_q  <= ERR_NONE;
            err_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            len_q         <= len_d;
            chk_q         <= chk_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            periph_q      <= periph_d;
            opcode_q      <= opcode_d;
            para_len_q    <= para_len_d;
            frame_error_q <= raise_err;
            error_type_q  <= error_type_d;
            if (raise_err && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= rx_data;
        end
    end

    assign para_data   = (state_q == StDrain) ? mem[addr] : 8'h00;
    assign cmd_periph  = periph_q;
    assign cmd_opcode  = opcode_q;
    assign para_len    = para_len_q;
    assign frame_error = frame_error_q;
    assign error_type  = error_type_q;
    assign err_cnt     = err_cnt_q;

endmodule
